// File: rtl/hazard_pkg.sv
// Shared types and legal parameter ranges for the RV32I pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 4;
  localparam int MDU_LAT_MIN  = 1;
  localparam int MDU_LAT_MAX  = 34;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_NONE = hz_ctrl_t'(8'h00);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rdE;
  logic              useRs1D;
  logic              useRs2D;
  logic              MemReadE;
  logic              mispredictE;
  logic              dmemWaitM;
  logic              mduE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic              loadUseStall;

  modport master (
    output rs1D, rs2D, rdE, useRs1D, useRs2D, MemReadE, mispredictE, dmemWaitM, mduE,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, loadUseStall
  );

  modport slave (
    input  rs1D, rs2D, rdE, useRs1D, useRs2D, MemReadE, mispredictE, dmemWaitM, mduE,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, loadUseStall
  );

endinterface

// File: rtl/hazard_ctrl_chk.sv
// Protocol checks on the hazard controller inputs.
module hazard_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic mispredict_e,
  input logic mdu_e
);

  // A MUL/DIV cannot also be a resolving branch.
  a_no_mdu_mispredict: assert property (@(posedge clk) disable iff (rst) !(mispredict_e && mdu_e))
    else $error("hazard_ctrl: mispredictE and mduE asserted together");

endmodule

// File: rtl/hazard_load_tracker.sv
// Tracks loads that have left EX but whose data is not yet forwardable, and flags
// D-stage sources that depend on them (or on the load currently in EX).
module hazard_load_tracker #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic              advance,
  output logic              hit
);

  function automatic logic src_hit(input logic use_src, input logic [REG_AW-1:0] src,
                                   input logic [REG_AW-1:0] rd);
    return use_src && (src != {REG_AW{1'b0}}) && (src == rd);
  endfunction

  if (DEPTH == 0) begin : g_no_chain
    logic unused_s;
    assign unused_s = ^{clk, rst, push, push_rd, advance};

    // Only the load in EX can cause a bubble.
    always_comb begin
      hit = ex_load && (src_hit(use_rs1, rs1, rd_e) || src_hit(use_rs2, rs2, rd_e));
    end
  end else begin : g_chain
    typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
    } ent_t;

    ent_t [DEPTH-1:0] chain_q;
    ent_t [DEPTH-1:0] chain_d;

    // Shift the chain whenever EX-MEM advances; a bubble enters when nothing is pushed.
    always_comb begin
      chain_d = chain_q;
      if (advance) begin
        chain_d[0] = '{valid: push, rd: push_rd};
        for (int k = 1; k < DEPTH; k++) begin
          chain_d[k] = chain_q[k-1];
        end
      end else begin
        chain_d = chain_q;
      end
    end

    // Match D sources against the EX load and every live chain entry.
    always_comb begin
      hit = ex_load && (src_hit(use_rs1, rs1, rd_e) || src_hit(use_rs2, rs2, rd_e));
      for (int k = 0; k < DEPTH; k++) begin
        if (chain_q[k].valid &&
            (src_hit(use_rs1, rs1, chain_q[k].rd) || src_hit(use_rs2, rs2, chain_q[k].rd))) begin
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end
    end

    // Chain state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        chain_q <= '0;
      end else begin
        chain_q <= chain_d;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: freeze > MDU hold > mispredict > load-use.
// Define HAZARD_MDU_EN to compile in the multi-cycle MUL/DIV hold counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT out of range");
  end
  if (MDU_LAT < MDU_LAT_MIN || MDU_LAT > MDU_LAT_MAX) begin : g_bad_mdu_lat
    $error("hazard_ctrl: MDU_LAT out of range");
  end

  hz_ctrl_t ctrl_s;
  logic     lus_s;
  logic     freeze_s;
  logic     hold_s;
  logic     hit_s;
  logic     push_s;
  logic     advance_s;

  assign freeze_s  = hz.dmemWaitM;
  // stallE / stallM derive from freeze and hold only, so the tracker update has no loop through hit_s.
  assign advance_s = ~freeze_s;
  assign push_s    = hz.MemReadE & (hz.rdE != {REG_AW{1'b0}}) & ~(freeze_s | hold_s);

  hazard_load_tracker #(
    .REG_AW (REG_AW),
    .DEPTH  (LOAD_LAT - 1)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .rs1     (hz.rs1D),
    .rs2     (hz.rs2D),
    .use_rs1 (hz.useRs1D),
    .use_rs2 (hz.useRs2D),
    .ex_load (hz.MemReadE),
    .rd_e    (hz.rdE),
    .push    (push_s),
    .push_rd (hz.rdE),
    .advance (advance_s),
    .hit     (hit_s)
  );

`ifdef HAZARD_MDU_EN
  localparam int   CNT_W     = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic MDU_MULTI = (MDU_LAT > 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt==1 marks the release cycle; the counter freezes along with the pipeline.
  always_comb begin
    cnt_d = cnt_q;
    if (freeze_s) begin
      cnt_d = cnt_q;
    end else if (cnt_q == CNT_W'(0)) begin
      if (hz.mduE) begin
        cnt_d = CNT_W'(MDU_LAT - 1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d = CNT_W'(0);
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // MDU occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_s = hz.mduE & (cnt_q != CNT_W'(1)) & MDU_MULTI;
`else
  assign hold_s = 1'b0;
`endif

  // Prioritised stall/flush decode.
  always_comb begin
    ctrl_s = HZ_NONE;
    lus_s  = 1'b0;
    if (rst) begin
      ctrl_s = HZ_NONE;
    end else if (freeze_s) begin
      ctrl_s.stall_f = 1'b1;
      ctrl_s.stall_d = 1'b1;
      ctrl_s.stall_e = 1'b1;
      ctrl_s.stall_m = 1'b1;
      ctrl_s.flush_w = 1'b1;
    end else if (hold_s) begin
      ctrl_s.stall_f = 1'b1;
      ctrl_s.stall_d = 1'b1;
      ctrl_s.stall_e = 1'b1;
      ctrl_s.flush_m = 1'b1;
    end else if (hz.mispredictE) begin
      // D holds a wrong-path instruction, so any load-use it shows is irrelevant.
      ctrl_s.flush_d = 1'b1;
      ctrl_s.flush_e = 1'b1;
    end else if (hit_s) begin
      ctrl_s.stall_f = 1'b1;
      ctrl_s.stall_d = 1'b1;
      ctrl_s.flush_e = 1'b1;
      lus_s          = 1'b1;
    end else begin
      ctrl_s = HZ_NONE;
    end
  end

  assign hz.stallF       = ctrl_s.stall_f;
  assign hz.stallD       = ctrl_s.stall_d;
  assign hz.stallE       = ctrl_s.stall_e;
  assign hz.stallM       = ctrl_s.stall_m;
  assign hz.flushD       = ctrl_s.flush_d;
  assign hz.flushE       = ctrl_s.flush_e;
  assign hz.flushM       = ctrl_s.flush_m;
  assign hz.flushW       = ctrl_s.flush_w;
  assign hz.loadUseStall = lus_s;

  hazard_ctrl_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .mispredict_e (hz.mispredictE),
    .mdu_e        (hz.mduE)
  );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage RV32I pipeline, sitting beside the datapath and driving all stage-register stall/flush enables. It generalises load-use detection to a configurable load latency using a sequential load tracker. It also adds data-memory wait freezing and optional multi-cycle MUL/DIV hold. Branch misprediction now takes priority over a load-use stall instead of combining with it.

## Interface
- REG_AW, 5: register address width.
- LOAD_LAT, 1: load-use bubbles required, 1..4.
- MDU_LAT, 4: cycles an MDU op occupies EX, 1..34 (only with HAZARD_MDU_EN).

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1D, rs2D  in  REG_AW  D-stage sources.
- useRs1D, useRs2D  in  1  source actually read (x0 never hazards).
- MemReadE  in  1  EX instruction is a load.
- rdE  in  REG_AW  EX destination.
- mispredictE  in  1  branch/jump mispredict resolved in EX.
- dmemWaitM  in  1  data memory not ready for the M-stage access.
- mduE  in  1  EX instruction is MUL/DIV (port exists always; ignored without macro).
- stallF, stallD, stallE, stallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM.
- flushD, flushE, flushM, flushW  out  1  bubble into IF-ID / ID-EX / EX-MEM / MEM-WB.
- loadUseStall  out  1  event pulse, load-use stall this cycle.

## Operation
- Outputs combinational from inputs and state; all outputs 0 while rst is high; state cleared at the edge.
- Priority, highest first: freeze (dmemWaitM) > MDU hold > mispredict > load-use.
- Freeze: stallF/D/E/M=1, flushW=1, all other flushes 0; tracker and MDU counter hold.
- MDU hold: stallF/D/E=1, flushM=1.
- Mispredict: flushD=1, flushE=1, no stall. A simultaneous load-use is dropped because D is wrong-path.
- Load-use: stallF=1, stallD=1, flushE=1, loadUseStall=1.
- Hazard match: a used source with nonzero address equals either
  - rdE while MemReadE, or
  - any valid tracker entry.
- Tracker: shift chain of LOAD_LAT-1 entries {valid, rd}.
  - When stallM=0: entry0 <= {MemReadE & rdE!=0 & !stallE, rdE}; entry k <= entry k-1; last entry dropped.
  - LOAD_LAT=1 means an empty chain, identical to the single-bubble behaviour.
- MDU counter cnt, width clog2(MDU_LAT), reset 0. Hold = mduE & cnt!=1 & MDU_LAT>1.
  - cnt==0 & mduE: cnt <= MDU_LAT-1.
  - cnt>1: cnt <= cnt-1.
  - cnt==1: cnt <= 0, op released.
  - Decrements are gated by freeze.
- mispredictE & mduE together is illegal; flagged by assertion.

## Timing
- Zero-latency combinational path from inputs to outputs; tracker state updates one edge later.
- Load followed by a dependent instruction gives exactly LOAD_LAT consecutive stall cycles.
- Dependence at distance d (1..LOAD_LAT) gives LOAD_LAT-d+1 stall cycles.
- MDU op occupies EX for exactly MDU_LAT non-frozen cycles, of which MDU_LAT-1 are hold cycles.
- Freeze mid-stall extends the stall by the freeze length; no counts are lost.
- Reset asserted mid-stall: the next cycle after deassertion has no stall.

## Configuration
- HAZARD_MDU_EN defined: MDU counter and hold logic compiled in.
- HAZARD_MDU_EN undefined: mduE ignored; cnt is absent; stallE and flushM are driven only by freeze (flushM=0).

## Structure
- Package hazard_pkg:
  - typedef reg_addr_t (REG_AW bits).
  - struct hz_ctrl_t grouping the eight stall/flush bits.
  - localparams for LOAD_LAT and MDU_LAT legal ranges.
- Sub-module hazard_load_tracker holds the shift chain and the match compare (inputs rs1/rs2/use, push, advance; output hit).

## Test plan
- LOAD_LAT=1: lw x5 in EX, D reads x5 → stallF/D=1 and flushE=1 for 1 cycle; rs=x0 → no stall.
- LOAD_LAT=3: lw x7, then a dependent instruction at distance 1 → 3 stall cycles; at distance 3 → 1 stall cycle.
- Mispredict while D depends on the EX load → flushD=1, flushE=1, stallF=0, loadUseStall=0.
- dmemWaitM held 2 cycles during the second of 3 load-use stalls → total 5 stall cycles, flushW=1 on freeze cycles only.
- HAZARD_MDU_EN, MDU_LAT=4: mduE held → stallE=1 for 3 cycles, released on the 4th; MDU_LAT=1 → no hold.
- rst asserted mid MDU hold and mid tracker → all outputs 0; after release, a dependent instruction at distance 2 does not stall.
